// File: rtl/sdram_arb_pkg.sv
// Shared command encodings and FSM state type for the SDRAM burst arbiter.
package sdram_arb_pkg;

  // Command type encodings presented to the SDRAM command engine.
  localparam logic [1:0] CMD_REF = 2'd0;
  localparam logic [1:0] CMD_WR  = 2'd1;
  localparam logic [1:0] CMD_RD  = 2'd2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StWaitInit,
    StArb,
    StReq,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/frame_addr_cnt.sv
// Frame word counter: advances by one burst per step and wraps at the last burst of a frame.
module frame_addr_cnt #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned CNT_W       = $clog2(FRAME_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [CNT_W-1:0] StepCnt = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LastCnt);
  assign wrap_o  = step_i && at_last;
  assign cnt_o   = cnt_q;

  // Next count: hold, step by one burst, or wrap to the start of the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = at_last ? '0 : cnt_q + StepCnt;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Serializes write/read burst triggers and refresh requests into SDRAM engine commands,
// owns the frame address counters and steers engine data strobes to the FIFOs.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              ref_req,
  input  logic              wr_trig,
  input  logic              rd_trig,
  output logic              cmd_req,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  input  logic              eng_wr_data_req,
  input  logic              eng_rd_data_vld,
  output logic              wfifo_rd_en,
  output logic              rfifo_wr_en,
  output logic              frame_valid,
  output logic              wr_frame_end,
  output logic              rd_frame_end,
  output logic              trig_ovf
);

  localparam int unsigned CntW = $clog2(FRAME_WORDS);

  arb_state_e        state_q, state_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              frame_valid_q, frame_valid_d;
  logic              trig_ovf_q, trig_ovf_d;
  // Set when WR was the most recently selected data command; cleared means WR wins a tie.
  logic              last_wr_q, last_wr_d;

  logic              handshake, done_ev, active;
  logic              cur_wr, cur_rd;
  logic              wr_hs, rd_hs;
  logic              wr_step, rd_step;
  logic              wr_wrap, rd_wrap;
  logic              wr_elig, rd_elig;
  logic [CntW-1:0]   wr_cnt, rd_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign handshake = (state_q == StReq) && cmd_ack;
  assign done_ev   = (state_q == StBusy) && cmd_done;
  assign active    = (state_q == StReq) || (state_q == StBusy);
  assign cur_wr    = active && (cmd_type_q == CMD_WR);
  assign cur_rd    = active && (cmd_type_q == CMD_RD);
  assign wr_hs     = handshake && (cmd_type_q == CMD_WR);
  assign rd_hs     = handshake && (cmd_type_q == CMD_RD);
  assign wr_step   = done_ev && (cmd_type_q == CMD_WR);
  assign rd_step   = done_ev && (cmd_type_q == CMD_RD);

  // Reads stay blocked until one complete frame has been written.
  assign wr_elig = wr_pend_q;
  assign rd_elig = rd_pend_q && frame_valid_q;

  assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_cnt);
  assign rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt);

  frame_addr_cnt #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .CNT_W      (CntW)
  ) u_wr_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .step_i(wr_step),
    .cnt_o (wr_cnt),
    .wrap_o(wr_wrap)
  );

  frame_addr_cnt #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .CNT_W      (CntW)
  ) u_rd_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .step_i(rd_step),
    .cnt_o (rd_cnt),
    .wrap_o(rd_wrap)
  );

  // Pending latches and sticky flags; a trigger coinciding with its own handshake re-arms cleanly.
  always_comb begin
    wr_pend_d     = (wr_pend_q && !wr_hs) || wr_trig;
    rd_pend_d     = (rd_pend_q && !rd_hs) || rd_trig;
    trig_ovf_d    = trig_ovf_q
                  || (wr_trig && wr_pend_q && !wr_hs)
                  || (rd_trig && rd_pend_q && !rd_hs);
    frame_valid_d = frame_valid_q || wr_wrap;
  end

  // FSM next state plus command selection: refresh first, then round-robin WR/RD.
  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    last_wr_d  = last_wr_q;
    unique case (state_q)
      StWaitInit: begin
        if (init_done) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (ref_req) begin
          cmd_type_d = CMD_REF;
          cmd_addr_d = '0;
          state_d    = StReq;
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          cmd_type_d = CMD_WR;
          cmd_addr_d = wr_addr;
          last_wr_d  = 1'b1;
          state_d    = StReq;
        end else if (rd_elig) begin
          cmd_type_d = CMD_RD;
          cmd_addr_d = rd_addr;
          last_wr_d  = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (cmd_ack) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cmd_done) begin
          state_d = StArb;
        end
      end
      default: state_d = StWaitInit;
    endcase
  end

  // State, command and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StWaitInit;
      cmd_type_q    <= CMD_REF;
      cmd_addr_q    <= '0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      trig_ovf_q    <= 1'b0;
      last_wr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_type_q    <= cmd_type_d;
      cmd_addr_q    <= cmd_addr_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      frame_valid_q <= frame_valid_d;
      trig_ovf_q    <= trig_ovf_d;
      last_wr_q     <= last_wr_d;
    end
  end

  assign cmd_req      = (state_q == StReq);
  assign cmd_type     = cmd_type_q;
  assign cmd_addr     = cmd_addr_q;
  // Strobes pass straight through so the FIFO and engine see zero added latency.
  assign wfifo_rd_en  = eng_wr_data_req && cur_wr;
  assign rfifo_wr_en  = eng_rd_data_vld && cur_rd;
  assign frame_valid  = frame_valid_q;
  assign wr_frame_end = wr_wrap;
  assign rd_frame_end = rd_wrap;
  assign trig_ovf     = trig_ovf_q;

endmodule
